bcdu_instr_executor: RTL and testbench

BCDU_INSTR_EXECUTOR -- requirements
Module: bcdu_instr_executor

---
 rtl/bcdu_instr_executor.sv | 210 +++++++++++++++++++++
 tb/tb_bcdu_instr_executor.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/bcdu_instr_executor.sv
// BCD calculator executor: digit entry, operand stack, digit-serial add/sub.
// Define BCDU_SUB_EN to build SUB (opcode 4); otherwise opcode 4 is illegal.
module bcdu_instr_executor #(
  parameter int NUM_DIGITS  = 4,
  parameter int STACK_DEPTH = 4
) (
  input  logic                             i_clk,
  input  logic                             i_rst_n,
  input  logic                             i_bcdu_valid,
  input  logic [15:0]                      i_bcdu_instr,
  output logic                             o_ready,
  output logic                             o_done,
  output logic [4*NUM_DIGITS-1:0]          o_value,
  output logic [$clog2(STACK_DEPTH+1)-1:0] o_depth,
  output logic [1:0]                       o_err
);
  localparam int W  = 4 * NUM_DIGITS;
  localparam int DW = $clog2(STACK_DEPTH + 1);
  localparam int CW = $clog2(NUM_DIGITS + 1);

  typedef enum logic [1:0] {IDLE, EXEC, WB} state_t;
  state_t state, state_nx;

  logic [W-1:0]  stk [STACK_DEPTH];
  logic [W-1:0]  entry, opa, opb, res;
  logic          entry_active, carry, done_q;
  logic [CW-1:0] ent_cnt, cyc;
  logic [DW-1:0] depth;
  logic [1:0]    err;

  logic [3:0] op, dig, dr;
  logic       accept, arith_ok, exec_start, c_nx;
  logic       op_nop, op_digit, op_enter, op_arith, op_clr, op_drop;
  logic [4:0] sum;
  logic [7:0] unused_bits;
`ifdef BCDU_SUB_EN
  logic       is_sub;
  logic [4:0] diff;
`endif

  function automatic logic [1:0] raise(input logic [1:0] cur,
                                       input logic [1:0] code);
    return (cur == 2'd0) ? code : cur;
  endfunction

  assign op          = i_bcdu_instr[15:12];
  assign dig         = i_bcdu_instr[3:0];
  assign unused_bits = i_bcdu_instr[11:4];
  assign accept      = i_bcdu_valid && (state == IDLE);
  assign arith_ok    = depth >= DW'(2);
  assign exec_start  = accept && op_arith && arith_ok;

  always_comb begin
    op_nop   = (op == 4'd0);
    op_digit = (op == 4'd1);
    op_enter = (op == 4'd2);
    op_arith = (op == 4'd3);
`ifdef BCDU_SUB_EN
    op_arith = op_arith || (op == 4'd4);
`endif
    op_clr   = (op == 4'd5);
    op_drop  = (op == 4'd6);
  end

  // One BCD digit per EXEC cycle, least significant first
  always_comb begin
    sum = {1'b0, opa[3:0]} + {1'b0, opb[3:0]} + {4'b0, carry};
    dr  = sum[3:0];
    c_nx = 1'b0;
    if (sum > 5'd9) begin
      dr   = 4'(sum - 5'd10);
      c_nx = 1'b1;
    end
`ifdef BCDU_SUB_EN
    diff = {1'b0, opa[3:0]} - {1'b0, opb[3:0]} - {4'b0, carry};
    if (is_sub) begin
      dr   = diff[3:0];
      c_nx = 1'b0;
      if (diff[4]) begin
        dr   = 4'(diff + 5'd10);
        c_nx = 1'b1;
      end
    end
`endif
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (exec_start) state_nx = EXEC;
      EXEC:    if (cyc == CW'(NUM_DIGITS - 1)) state_nx = WB;
      WB:      state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    o_ready = (state == IDLE);
    o_done  = done_q || (state == WB);
    o_depth = depth;
    o_err   = err;
    if (entry_active)     o_value = entry;
    else if (depth != '0) o_value = stk[0];
    else                  o_value = '0;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < STACK_DEPTH; i++) stk[i] <= '0;
      entry        <= '0;
      entry_active <= 1'b0;
      ent_cnt      <= '0;
      depth        <= '0;
      err          <= 2'd0;
      done_q       <= 1'b0;
      opa          <= '0;
      opb          <= '0;
      res          <= '0;
      carry        <= 1'b0;
      cyc          <= '0;
`ifdef BCDU_SUB_EN
      is_sub       <= 1'b0;
`endif
    end else begin
      done_q <= accept && !exec_start;
      if (accept) begin
        unique case (1'b1)
          op_nop: ;
          op_digit: begin
            if (dig > 4'd9) begin
              err <= raise(err, 2'd1);
            end else if (ent_cnt != CW'(NUM_DIGITS)) begin
              entry        <= (entry << 4) | W'(dig);
              ent_cnt      <= ent_cnt + CW'(1);
              entry_active <= 1'b1;
            end
          end
          op_enter: begin
            if (depth == DW'(STACK_DEPTH)) begin
              err <= raise(err, 2'd3);
            end else begin
              for (int i = 1; i < STACK_DEPTH; i++) stk[i] <= stk[i-1];
              stk[0]       <= entry;
              depth        <= depth + DW'(1);
              entry        <= '0;
              entry_active <= 1'b0;
              ent_cnt      <= '0;
            end
          end
          op_arith: begin
            if (!arith_ok) begin
              err <= raise(err, 2'd2);
            end else begin
              opa   <= stk[1];
              opb   <= stk[0];
              res   <= '0;
              carry <= 1'b0;
              cyc   <= '0;
`ifdef BCDU_SUB_EN
              is_sub <= (op == 4'd4);
`endif
            end
          end
          op_clr: begin
            for (int i = 0; i < STACK_DEPTH; i++) stk[i] <= '0;
            depth        <= '0;
            entry        <= '0;
            entry_active <= 1'b0;
            ent_cnt      <= '0;
            err          <= 2'd0;
          end
          op_drop: begin
            if (depth == '0) begin
              err <= raise(err, 2'd2);
            end else begin
              for (int i = 0; i < STACK_DEPTH - 1; i++) stk[i] <= stk[i+1];
              stk[STACK_DEPTH-1] <= '0;
              depth              <= depth - DW'(1);
            end
          end
          default: err <= raise(err, 2'd1);
        endcase
      end
      if (state == EXEC) begin
        opa   <= opa >> 4;
        opb   <= opb >> 4;
        res   <= {dr, res[W-1:4]};
        carry <= c_nx;
        cyc   <= cyc + CW'(1);
      end
      // Result only lands on the WB edge, so a reset never leaves a partial write
      if (state == WB) begin
        for (int i = 1; i < STACK_DEPTH - 1; i++) stk[i] <= stk[i+1];
        stk[STACK_DEPTH-1] <= '0;
        stk[0]             <= res;
        depth              <= depth - DW'(1);
`ifdef BCDU_SUB_EN
        if (carry) err <= raise(err, is_sub ? 2'd2 : 2'd3);
`else
        if (carry) err <= raise(err, 2'd3);
`endif
      end
    end
  end
endmodule

// File: tb/tb_bcdu_instr_executor.sv
// Bench for bcdu_instr_executor: directed scenarios plus random instruction
// streams checked against a decimal-arithmetic stack model.
module tb_bcdu_instr_executor;
  localparam int ND  = 4;
  localparam int SD  = 4;
  localparam int MOD = 10000;
`ifdef BCDU_SUB_EN
  localparam bit SUB = 1'b1;
`else
  localparam bit SUB = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid = 1'b0;
  logic [15:0] instr = '0;
  logic        ready, done;
  logic [15:0] value;
  logic [2:0]  depth;
  logic [1:0]  err;

  int checks = 0;
  int passed = 0;
  int fails  = 0;

  int mstk[$];
  int ment, mcnt, merr;
  bit mact;

  bcdu_instr_executor #(.NUM_DIGITS(ND), .STACK_DEPTH(SD)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_bcdu_valid(valid),
    .i_bcdu_instr(instr), .o_ready(ready), .o_done(done),
    .o_value(value), .o_depth(depth), .o_err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    assert (got === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r = '0;
    for (int i = 0; i < ND; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  function automatic logic [15:0] expv();
    if (mact) return to_bcd(ment);
    if (mstk.size() != 0) return to_bcd(mstk[$]);
    return 16'h0;
  endfunction

  function automatic void mraise(input int c);
    if (merr == 0) merr = c;
  endfunction

  function automatic void mreset();
    mstk.delete();
    ment = 0; mcnt = 0; mact = 0; merr = 0;
  endfunction

  function automatic bit model(input int op, input int d);
    int t, s, r;
    case (op)
      0: ;
      1: if (d > 9) mraise(1);
         else if (mcnt < ND) begin ment = ment * 10 + d; mcnt++; mact = 1; end
      2: if (mstk.size() == SD) mraise(3);
         else begin mstk.push_back(ment); ment = 0; mcnt = 0; mact = 0; end
      3, 4: begin
        if (op == 4 && !SUB) mraise(1);
        else if (mstk.size() < 2) mraise(2);
        else begin
          t = mstk.pop_back();
          s = mstk.pop_back();
          r = (op == 3) ? s + t : s - t;
          if (r >= MOD) begin r -= MOD; mraise(3); end
          if (r < 0) begin r += MOD; mraise(2); end
          mstk.push_back(r);
          return 1;
        end
      end
      5: mreset();
      6: if (mstk.size() == 0) mraise(2);
         else void'(mstk.pop_back());
      default: mraise(1);
    endcase
    return 0;
  endfunction

  task automatic check_state(input string tag);
    chk({tag, "_value"}, 32'(value), 32'(expv()));
    chk({tag, "_depth"}, 32'(depth), 32'(mstk.size()));
    chk({tag, "_err"},   32'(err),   32'(merr));
  endtask

  task automatic run(input logic [3:0] op, input logic [3:0] d);
    bit ex, dn;
    int lowc;
    @(negedge clk);
    valid = 1'b1;
    instr = {op, 8'($urandom), d};
    @(posedge clk); #1;
    valid = 1'b0;
    ex = model(int'(op), int'(d));
    if (!ex) chk("done", 32'(done), 32'd1);
    lowc = 0; dn = 0;
    while (!ready && lowc < 3 * ND) begin
      dn |= done;
      lowc++;
      @(posedge clk); #1;
    end
    chk("busy_cycles", lowc, ex ? ND + 1 : 0);
    if (ex) begin
      chk("wb_done", 32'(dn), 32'd1);
      chk("done_pulse", 32'(done), 32'd0);
    end
    check_state("op");
  endtask

  initial begin
    int lowc;
    int wop[16] = '{1, 1, 1, 1, 2, 2, 2, 3, 3, 4, 4, 5, 6, 6, 0, 9};
    int o, dd;
    mreset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_done",  32'(done),  32'd0);
    check_state("rst");
    @(negedge clk) rst_n = 1'b1;

    run(1, 1); run(1, 2); run(2, 0); run(1, 3); run(1, 4); run(2, 0);
    run(3, 0);
    chk("add_46", 32'(value), 32'h46);

    run(5, 0);
    repeat (5) run(1, 9);
    chk("entry_9999", 32'(value), 32'h9999);
    run(2, 0); run(1, 0); run(1, 0); run(1, 0); run(1, 1); run(2, 0);
    run(3, 0);
    chk("add_wrap_err", 32'(err), 32'd3);

    run(5, 0);
    run(1, 3); run(2, 0); run(1, 5); run(2, 0); run(4, 0);
    chk("sub_err", 32'(err), SUB ? 32'd2 : 32'd1);

    run(5, 0);
    run(1, 7); run(2, 0); run(3, 0);
    chk("add_under", 32'(err), 32'd2);
    run(5, 0);
    run(1, 12);
    chk("digit_bad", 32'(err), 32'd1);

    run(5, 0);
    repeat (5) run(2, 0);
    chk("stack_full", 32'(err), 32'd3);

    // valid held through EXEC: the waiting DIGIT lands only after o_ready returns
    run(5, 0);
    run(1, 1); run(2, 0); run(1, 2); run(2, 0);
    @(negedge clk);
    valid = 1'b1;
    instr = 16'h3000;
    @(posedge clk); #1;
    instr = 16'h1007;
    void'(model(3, 0));
    lowc = 0;
    while (!ready && lowc < 3 * ND) begin lowc++; @(posedge clk); #1; end
    chk("hold_busy", lowc, ND + 1);
    check_state("hold_pre");
    @(posedge clk); #1;
    valid = 1'b0;
    void'(model(1, 7));
    check_state("hold_post");

    // reset mid-EXEC
    run(5, 0);
    run(1, 4); run(2, 0); run(1, 5); run(2, 0);
    @(negedge clk);
    valid = 1'b1;
    instr = 16'h3000;
    @(posedge clk); #1;
    valid = 1'b0;
    @(posedge clk); #1;
    chk("mid_exec_busy", 32'(ready), 32'd0);
    rst_n = 1'b0;
    mreset();
    #1;
    chk("arst_ready", 32'(ready), 32'd1);
    chk("arst_done",  32'(done),  32'd0);
    check_state("arst");
    @(posedge clk); #1;
    chk("arst_ready_next", 32'(ready), 32'd1);
    check_state("arst_next");
    @(negedge clk) rst_n = 1'b1;

    for (int n = 0; n < 150; n++) begin
      o = wop[$urandom_range(0, 15)];
      if (o == 9) o = $urandom_range(7, 15);
      dd = ($urandom_range(0, 7) == 0) ? $urandom_range(10, 15)
                                       : $urandom_range(0, 9);
      run(4'(o), 4'(dd));
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
